// File: rtl/vmem_port_arbiter_if.sv
// Requester-side and X-IF memory-side bundle for vmem_port_arbiter.
// master = requesters plus memory port (environment), slave = the arbiter.
interface vmem_port_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*ADDR_W-1:0] req_wdata;
    logic [N_REQ*4-1:0]      req_be;

    logic                    mem_valid;
    logic                    mem_ready;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_wdata;
    logic [3:0]              mem_be;

    logic                    mem_result_valid;
    logic [ADDR_W-1:0]       mem_result_rdata;

    logic [N_REQ-1:0]        rsp_valid;
    logic [ADDR_W-1:0]       rsp_rdata;
    logic                    busy;
    logic                    err;

    modport master (
        output req_valid, req_last, req_we, req_addr, req_wdata, req_be,
        output mem_ready, mem_result_valid, mem_result_rdata,
        input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        input  rsp_valid, rsp_rdata, busy, err
    );

    modport slave (
        input  req_valid, req_last, req_we, req_addr, req_wdata, req_be,
        input  mem_ready, mem_result_valid, mem_result_rdata,
        output req_ready, mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        output rsp_valid, rsp_rdata, busy, err
    );
endinterface

// File: rtl/vmem_port_arbiter.sv
// Round-robin arbiter of N_REQ vector memory requesters onto one X-IF memory port; VMEM_ARB_FIXED_PRIO_EN selects fixed priority.
// Zero-latency grant and result routing; bursts keep the grant; stalls while MAX_OUTST beats are outstanding.
module vmem_port_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vmem_port_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] arb_base;
    logic [IDX_W-1:0] tag_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             fld_en;
    logic             mem_vld;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] head;

`ifdef VMEM_ARB_FIXED_PRIO_EN
    assign arb_base = '0;
`else
    logic [IDX_W-1:0] rr_ptr;
    assign arb_base = rr_ptr;
`endif

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        if (state == LOCKED) begin
            win_idx = grant_q;
            win_vld = bus.req_valid[grant_q];
        end else begin
            // walk from the farthest candidate down so the one nearest arb_base wins
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (bus.req_valid[wrap_add(arb_base, i)]) begin
                    win_vld = 1'b1;
                    win_idx = wrap_add(arb_base, i);
                end
            end
        end
    end

    // a full tag FIFO blocks issue even if a result pops it this cycle
    assign fld_en  = !rst_i && win_vld;
    assign mem_vld = fld_en && (count != FULL_CNT);
    assign accept  = mem_vld && bus.mem_ready;
    assign pop     = bus.mem_result_valid && (count != '0);
    assign head    = tag_mem[rd_ptr];

    assign bus.mem_valid = mem_vld;
    assign bus.mem_addr  = fld_en ? bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W]  : '0;
    assign bus.mem_wdata = fld_en ? bus.req_wdata[int'(win_idx)*ADDR_W +: ADDR_W] : '0;
    assign bus.mem_be    = fld_en ? bus.req_be[int'(win_idx)*4 +: 4]              : 4'h0;
    assign bus.mem_we    = fld_en && bus.req_we[win_idx];
    assign bus.rsp_rdata = pop ? bus.mem_result_rdata : '0;
    assign bus.busy      = (state == LOCKED) || (count != '0);
    assign bus.err       = err_q;

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (accept) bus.req_ready[win_idx] = 1'b1;
        if (pop)    bus.rsp_valid[head]    = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (accept) tag_mem[wr_ptr] <= win_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB;
            grant_q <= '0;
`ifndef VMEM_ARB_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (bus.req_last[win_idx]) begin
                    state  <= ARB;
`ifndef VMEM_ARB_FIXED_PRIO_EN
                    rr_ptr <= wrap_add(win_idx, 1);
`endif
                end else begin
                    state   <= LOCKED;
                    grant_q <= win_idx;
                end
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;
            if (bus.mem_result_valid && (count == '0)) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Randomized bench for vmem_port_arbiter: a cycle-level reference of the arbitration rules checks the memory port,
// and a scoreboard of expected results (owner, data) is matched against rsp_valid/rsp_rdata by a separate monitor.
module tb_vmem_port_arbiter;
    localparam int N  = 3;
    localparam int MO = 4;
    localparam int W  = 32;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         we;
        logic [3:0]   be;
        logic         last;
    } beat_t;

    typedef struct packed {
        int           tag;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vmem_port_arbiter_if #(.N_REQ(N), .ADDR_W(W)) bus ();

    vmem_port_arbiter #(.N_REQ(N), .MAX_OUTST(MO), .ADDR_W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    beat_t        bq [N][$];
    logic [W-1:0] mem_pend [$];
    exp_t         sb [$];
    logic [N-1:0] vld = '0;
    logic [N-1:0] adv = '0;
    int           addr_ctr [N];
    int           lock   = -1;
    int           rr     = 0;
    int           outst  = 0;
    bit           merr   = 0;
    int           res_pct = 30;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arbiter: who should own the port this cycle, derived from the arbitration rules
    always @(negedge clk) begin : model
        int w;
        int k;
        bit can;
        bit acc;
        logic [N-1:0] er;
        logic [W-1:0] rd;
        if (rst) begin
            lock = -1; rr = 0; outst = 0; merr = 0; adv = '0;
        end else begin
            w = -1;
            if (lock >= 0) begin
                if (bus.req_valid[lock]) w = lock;
            end else begin
                for (int i = 0; i < N; i++) begin
`ifdef VMEM_ARB_FIXED_PRIO_EN
                    k = i;
`else
                    k = (rr + i) % N;
`endif
                    if (w < 0 && bus.req_valid[k]) w = k;
                end
            end
            can = (w >= 0) && (outst < MO);
            acc = can && bus.mem_ready;
            check("mem_valid", bus.mem_valid, can);
            if (can) begin
                check("mem_addr",  bus.mem_addr,  bus.req_addr[w*W +: W]);
                check("mem_wdata", bus.mem_wdata, bus.req_wdata[w*W +: W]);
                check("mem_be",    bus.mem_be,    bus.req_be[w*4 +: 4]);
                check("mem_we",    bus.mem_we,    bus.req_we[w]);
            end
            er = '0;
            if (acc) er[w] = 1'b1;
            check("req_ready", bus.req_ready, er);
            check("busy", bus.busy, (lock >= 0) || (outst != 0));
            check("err", bus.err, merr);
            if (bus.mem_result_valid) begin
                if (outst == 0) merr = 1;
                else outst--;
            end
            adv = er;
            if (acc) begin
                outst++;
                rd = $urandom;
                mem_pend.push_back(rd);
                sb.push_back('{w, rd});
                if (bus.req_last[w]) begin
                    lock = -1;
                    rr = (w + 1) % N;
                end else begin
                    lock = w;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [N-1:0] eo;
        if (!rst) begin
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    eo = '0;
                    eo[e.tag] = 1'b1;
                    check("rsp_owner", bus.rsp_valid, eo);
                    check("rsp_rdata", bus.rsp_rdata, e.data);
                end
            end else begin
                check("rsp_rdata_idle", bus.rsp_rdata, 0);
                if (bus.mem_result_valid && sb.size() > 0) begin
                    eo = '0;
                    eo[sb[0].tag] = 1'b1;
                    check("rsp_missing", bus.rsp_valid, eo);
                end
            end
        end
    end

    task automatic gen(input int r, input int nb, input int max_log);
        beat_t b;
        int len;
        for (int j = 0; j < nb; j++) begin
            len = 1 << $urandom_range(0, max_log);
            for (int m = 0; m < len; m++) begin
                b.addr  = 32'h1000 * (r + 1) + 32'(addr_ctr[r] * 4);
                b.wdata = $urandom;
                b.we    = 1'($urandom_range(0, 1));
                b.be    = 4'($urandom_range(0, 15));
                b.last  = (m == len - 1);
                addr_ctr[r]++;
                bq[r].push_back(b);
            end
        end
    endtask

    task automatic step();
        beat_t b;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (adv[r] && bq[r].size() > 0) begin
                bq[r].delete(0);
                vld[r] = 1'b0;
            end
            if (!vld[r] && bq[r].size() > 0 && $urandom_range(0, 3) != 0) vld[r] = 1'b1;
            bus.req_valid[r] = vld[r];
            if (bq[r].size() > 0) begin
                b = bq[r][0];
                bus.req_addr[r*W +: W]  = b.addr;
                bus.req_wdata[r*W +: W] = b.wdata;
                bus.req_be[r*4 +: 4]    = b.be;
                bus.req_we[r]           = b.we;
                bus.req_last[r]         = b.last;
            end
        end
        bus.mem_ready = ($urandom_range(0, 99) < 75);
        if (mem_pend.size() > 0 && $urandom_range(0, 99) < res_pct) begin
            bus.mem_result_valid = 1'b1;
            bus.mem_result_rdata = mem_pend.pop_front();
        end else begin
            bus.mem_result_valid = 1'b0;
            bus.mem_result_rdata = $urandom;
        end
    endtask

    function automatic bit idle();
        bit e;
        e = (sb.size() == 0) && (mem_pend.size() == 0);
        for (int r = 0; r < N; r++) if (bq[r].size() != 0) e = 0;
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_valid"}, bus.mem_valid, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_err"},       bus.err, 0);
    endtask

    initial begin
        bit ok;
        for (int r = 0; r < N; r++) addr_ctr[r] = 0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
        bus.mem_ready = 1'b0; bus.mem_result_valid = 1'b0; bus.mem_result_rdata = '0;

        // reset holds every output low even with live inputs
        #1 rst = 1'b1;
        bus.req_valid = '1; bus.req_addr = '1; bus.mem_ready = 1'b1;
        bus.mem_result_valid = 1'b1; bus.mem_result_rdata = 32'hDEADBEEF;
        #1 check_all_zero("reset");
        bus.req_valid = '0; bus.req_addr = '0; bus.mem_result_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // result with nothing outstanding: dropped, err becomes sticky
        step();
        bus.mem_result_valid = 1'b1;
        bus.mem_result_rdata = 32'hBAD0BAD0;
        step();
        step();
        check("err_sticky", bus.err, 1);

        // random traffic: slow results first to exercise the full FIFO, then faster
        for (int r = 0; r < N; r++) gen(r, 10, 3);
        res_pct = 15;
        repeat (200) step();
        res_pct = 60;
        for (int c = 0; c < 5000 && !idle(); c++) step();
        check("drain1", idle(), 1);

        // reset during a locked burst
        gen(0, 1, 0);
        bq[0].delete();
        for (int m = 0; m < 8; m++) bq[0].push_back('{32'(m * 4), $urandom, 1'b0, 4'hF, (m == 7)});
        gen(1, 2, 0);
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            step();
            ok = (lock == 0);
        end
        check("lock_reached", ok, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        for (int r = 0; r < N; r++) bq[r].delete();
        mem_pend.delete();
        sb.delete();
        vld = '0;
        bus.req_valid = '0;
        bus.mem_result_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < N; r++) gen(r, 4, 2);
        for (int c = 0; c < 3000 && !idle(); c++) step();
        check("drain2", idle(), 1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
